// File: rtl/retire_trace_pkg.sv
// Shared types for the retirement trace transmitter: record layout, format
// encoding and the opcodes that drive format decode.
package retire_trace_pkg;

    localparam int unsigned SEQ_W = 16;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } instr_fmt_e;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic             wen;
        logic [4:0]       rd;
        logic [31:0]      wdata;
        instr_fmt_e       fmt;
    } trace_rec_t;

    localparam int unsigned REC_W = $bits(trace_rec_t);

    function automatic instr_fmt_e decode_fmt(input logic [31:0] instr);
        instr_fmt_e fmt;
        case (instr[31:26])
            OP_RTYPE:     fmt = FMT_R;
            OP_J, OP_JAL: fmt = FMT_J;
            default:      fmt = FMT_I;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/retire_trace_tx_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always on o_rdata (zero when
// empty). Pointers carry an extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/retire_trace_tx.sv
// Retirement trace transmitter: captures one record per retired instruction,
// numbers it, queues it and streams it out with drop accounting and back-pressure.
module retire_trace_tx
    import retire_trace_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter bit          FILTER_NOP  = 1'b1,
    parameter int unsigned STALL_SLACK = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_retire,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_instr,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_data,
    output logic        tr_valid,
    input  logic        tr_ready,
    output logic [15:0] tr_seq,
    output logic [31:0] tr_pc,
    output logic [31:0] tr_instr,
    output logic [31:0] tr_wdata,
    output logic        tr_wen,
    output logic [4:0]  tr_rd,
    output logic [1:0]  tr_type,
    output logic        stall_req,
    output logic        overflow,
    output logic [15:0] drop_cnt,
    input  logic        clr_overflow
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = AW + 1;
    localparam int unsigned STALL_TH = DEPTH - STALL_SLACK;

    logic [SEQ_W-1:0] r_seq_ctr;
    logic             r_overflow;
    logic [15:0]      r_drop_cnt;
    logic             r_stall_req;

    trace_rec_t       w_cap_rec;
    trace_rec_t       w_head_rec;
    logic             w_capture;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_empty;
    logic             w_full;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_count_next;

    assign w_capture = wb_retire && !(FILTER_NOP && (wb_instr == 32'd0));
    assign w_pop     = !w_empty && tr_ready;
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && !w_push;

    always_comb begin
        w_cap_rec       = '0;
        w_cap_rec.seq   = r_seq_ctr;
        w_cap_rec.pc    = wb_pc;
        w_cap_rec.instr = wb_instr;
        w_cap_rec.wen   = wb_reg_write;
        w_cap_rec.rd    = wb_reg_write ? wb_dest : 5'd0;
        w_cap_rec.wdata = wb_data;
        w_cap_rec.fmt   = decode_fmt(wb_instr);
    end

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_wdata (w_cap_rec),
        .i_pop   (w_pop),
        .o_rdata (w_head_rec),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

    // Dropped captures still consume a sequence number so the consumer sees the gap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seq_ctr <= '0;
        end else if (w_capture) begin
            r_seq_ctr <= r_seq_ctr + 1'b1;
        end
    end

    // A drop in the same cycle as a clear wins and restarts the count at one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_overflow)
                r_drop_cnt <= 16'd1;
            else if (r_drop_cnt != 16'hFFFF)
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_req <= 1'b0;
        end else begin
            r_stall_req <= (STALL_SLACK != 0) && (32'(w_count_next) >= STALL_TH);
        end
    end

    assign tr_valid  = !w_empty;
    assign tr_seq    = w_head_rec.seq;
    assign tr_pc     = w_head_rec.pc;
    assign tr_instr  = w_head_rec.instr;
    assign tr_wen    = w_head_rec.wen;
    assign tr_rd     = w_head_rec.rd;
    assign tr_wdata  = w_head_rec.wdata;
    assign tr_type   = w_head_rec.fmt;
    assign stall_req = r_stall_req;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_retire_trace_tx.sv
// Scoreboard bench for retire_trace_tx: stimulus pushes expected records,
// a negedge monitor pops and compares on every handshake.
module tb_retire_trace_tx;

    localparam int DEPTH = 8;
    localparam int TH    = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        wb_retire = 1'b0;
    logic [31:0] wb_pc = '0;
    logic [31:0] wb_instr = '0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_dest = '0;
    logic [31:0] wb_data = '0;
    logic        tr_ready = 1'b0;
    logic        clr_overflow = 1'b0;
    logic        tr_valid;
    logic [15:0] tr_seq;
    logic [31:0] tr_pc, tr_instr, tr_wdata;
    logic        tr_wen;
    logic [4:0]  tr_rd;
    logic [1:0]  tr_type;
    logic        stall_req;
    logic        overflow;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    retire_trace_tx #(.DEPTH(DEPTH), .FILTER_NOP(1'b1), .STALL_SLACK(2)) dut (
        .clk(clk), .reset_n(reset_n), .wb_retire(wb_retire), .wb_pc(wb_pc),
        .wb_instr(wb_instr), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest),
        .wb_data(wb_data), .tr_valid(tr_valid), .tr_ready(tr_ready),
        .tr_seq(tr_seq), .tr_pc(tr_pc), .tr_instr(tr_instr), .tr_wdata(tr_wdata),
        .tr_wen(tr_wen), .tr_rd(tr_rd), .tr_type(tr_type), .stall_req(stall_req),
        .overflow(overflow), .drop_cnt(drop_cnt), .clr_overflow(clr_overflow)
    );

    wire [119:0] dut_rec = {tr_seq, tr_pc, tr_instr, tr_wen, tr_rd, tr_wdata, tr_type};

    logic [119:0] exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           m_occ = 0;
    logic [15:0]  m_seq = '0;
    logic         m_ovf = 1'b0;
    int           m_drop = 0;
    bit           pend = 1'b0;
    bit           quiet = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected record straight from the field rules: rd masked when no write,
    // format from the top six opcode bits.
    function automatic logic [119:0] make_rec(input logic [15:0] seq, input logic [31:0] pc,
                                              input logic [31:0] instr, input bit wen,
                                              input logic [4:0] rd, input logic [31:0] data);
        logic [5:0] op;
        logic [1:0] t;
        op = instr[31:26];
        if (op == 6'h00)                     t = 2'd0;
        else if (op == 6'h02 || op == 6'h03) t = 2'd2;
        else                                 t = 2'd1;
        return {seq, pc, instr, wen, (wen ? rd : 5'd0), data, t};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom % 6)
            0: ins[31:26] = 6'h00;
            1: ins[31:26] = 6'h02;
            2: ins[31:26] = 6'h03;
            3: ins = 32'd0;
            default: ;
        endcase
        return ins;
    endfunction

    // One clock: check committed state, then drive the next edge and advance the model.
    task automatic step(input bit ret, input logic [31:0] pc, input logic [31:0] instr,
                        input bit wen, input logic [4:0] rd, input logic [31:0] data,
                        input bit rdy, input bit clr);
        bit pop, cap, push;
        @(posedge clk); #1;
        check("valid", 128'(tr_valid), 128'(m_occ > 0));
        check("stall_req", 128'(stall_req), 128'(m_occ >= TH));
        check("overflow", 128'(overflow), 128'(m_ovf));
        check("drop_cnt", 128'(drop_cnt), 128'(m_drop));
        wb_retire = ret; wb_pc = pc; wb_instr = instr; wb_reg_write = wen;
        wb_dest = rd; wb_data = data; tr_ready = rdy; clr_overflow = clr;
        pop  = (m_occ > 0) && rdy;
        cap  = ret && (instr != 32'd0);
        push = cap && ((m_occ < DEPTH) || pop);
        pend = push;
        if (push) exp_q.push_back(make_rec(m_seq, pc, instr, wen, rd, data));
        if (cap) m_seq = m_seq + 16'd1;
        m_occ = m_occ + int'(push) - int'(pop);
        if (cap && !push) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : ((m_drop < 65535) ? m_drop + 1 : m_drop);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic cap_rand(input bit rdy);
        logic [31:0] ins;
        ins = $urandom;
        if (ins == 32'd0) ins = 32'h20000001;
        step(1'b1, $urandom, ins, 1'($urandom), 5'($urandom), $urandom, rdy, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        wb_retire = 1'b0; wb_instr = '0; tr_ready = 1'b0; clr_overflow = 1'b0;
        #1;
        check("rst_valid", 128'(tr_valid), 128'(0));
        check("rst_data", 128'(dut_rec), 128'(0));
        check("rst_stall", 128'(stall_req), 128'(0));
        check("rst_overflow", 128'(overflow), 128'(0));
        check("rst_drop_cnt", 128'(drop_cnt), 128'(0));
        exp_q.delete();
        m_occ = 0; m_seq = '0; m_ovf = 1'b0; m_drop = 0; pend = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        int occ;
        if (reset_n) begin
            occ = exp_q.size() - int'(pend);
            check("mon_valid", 128'(tr_valid), 128'(occ > 0));
            if (tr_valid && occ > 0) begin
                if (tr_ready) begin
                    check("record", 128'(dut_rec), 128'(exp_q[0]));
                    if (!quiet)
                        $display("rec seq=%h pc=%h instr=%h wen=%0d rd=%0d wdata=%h type=%0d",
                                 tr_seq, tr_pc, tr_instr, tr_wen, tr_rd, tr_wdata, tr_type);
                    void'(exp_q.pop_front());
                end else begin
                    check("held_head", 128'(dut_rec), 128'(exp_q[0]));
                end
            end
        end
    end

    initial begin
        do_reset();

        // Single retirement and format decode.
        step(1'b1, 32'h400, 32'h012A4020, 1'b1, 5'd8, 32'd5, 1'b1, 1'b0);
        idle(1'b1);
        check("single_seq", 128'(tr_seq), 128'(0));
        check("single_type", 128'(tr_type), 128'(0));
        check("single_rd", 128'(tr_rd), 128'(8));
        check("single_wdata", 128'(tr_wdata), 128'(5));
        check("single_pc", 128'(tr_pc), 128'(32'h400));
        step(1'b1, 32'h404, 32'h08000010, 1'b0, 5'd3, 32'd0, 1'b1, 1'b0);
        idle(1'b1);
        check("j_type", 128'(tr_type), 128'(2));
        check("j_rd_masked", 128'(tr_rd), 128'(0));
        step(1'b1, 32'h408, 32'h8C080004, 1'b1, 5'd8, 32'h1234, 1'b1, 1'b0);
        idle(1'b1);
        check("lw_type", 128'(tr_type), 128'(1));
        check("lw_seq", 128'(tr_seq), 128'(2));
        step(1'b1, 32'h40C, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        idle(1'b1);
        check("nop_filtered", 128'(tr_valid), 128'(0));
        step(1'b1, 32'h410, 32'h012A4020, 1'b1, 5'd9, 32'd7, 1'b1, 1'b0);
        idle(1'b1);
        check("after_nop_seq", 128'(tr_seq), 128'(3));

        // Back-pressure: 10 captures into an 8-deep FIFO with the consumer stalled.
        do_reset();
        for (int i = 0; i < 10; i++) cap_rand(1'b0);
        idle(1'b0);
        check("bp_overflow", 128'(overflow), 128'(1));
        check("bp_drop_cnt", 128'(drop_cnt), 128'(2));
        check("bp_stall", 128'(stall_req), 128'(1));
        check("bp_head_seq", 128'(tr_seq), 128'(0));
        for (int i = 0; i < 8; i++) idle(1'b1);
        cap_rand(1'b1);
        idle(1'b1);
        check("bp_next_seq", 128'(tr_seq), 128'(10));
        idle(1'b1);

        // Full FIFO: hold three cycles, then capture with a simultaneous pop.
        for (int i = 0; i < 8; i++) cap_rand(1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        cap_rand(1'b1);
        idle(1'b0);
        check("full_pp_drop_cnt", 128'(drop_cnt), 128'(2));
        check("full_pp_stall", 128'(stall_req), 128'(1));

        // Clear coinciding with a drop, then a plain clear.
        step(1'b1, 32'h500, 32'h24010001, 1'b1, 5'd1, 32'd1, 1'b0, 1'b1);
        idle(1'b0);
        check("clr_drop_cnt", 128'(drop_cnt), 128'(1));
        check("clr_drop_ovf", 128'(overflow), 128'(1));
        step(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        idle(1'b0);
        check("clr_cnt_zero", 128'(drop_cnt), 128'(0));
        check("clr_ovf_zero", 128'(overflow), 128'(0));

        // Reset with 4 entries queued.
        for (int i = 0; i < 10; i++) idle(1'b1);
        for (int i = 0; i < 4; i++) cap_rand(1'b0);
        idle(1'b0);
        do_reset();
        cap_rand(1'b1);
        idle(1'b1);
        check("post_rst_seq", 128'(tr_seq), 128'(0));

        // Randomised traffic with varying consumer readiness.
        for (int blk = 0; blk < 30; blk++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(10, 100);
            for (int i = 0; i < 100; i++) begin
                step(($urandom % 4) != 0, $urandom, rand_instr(), 1'($urandom), 5'($urandom),
                     $urandom, ($urandom % 100) < rdy_pct, ($urandom % 60) == 0);
            end
        end
        for (int i = 0; i < 10; i++) idle(1'b1);

        // Sequence wrap.
        do_reset();
        quiet = 1'b1;
        while (m_seq != 16'hFFFF) cap_rand(1'b1);
        quiet = 1'b0;
        cap_rand(1'b1);
        cap_rand(1'b1);
        check("wrap_seq_ffff", 128'(tr_seq), 128'(16'hFFFF));
        idle(1'b1);
        check("wrap_seq_0000", 128'(tr_seq), 128'(0));
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("final_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/retire_trace_tx.md
# retire_trace_tx

Transmit side of the instruction-retirement trace interface. Sits beside the Write-Back stage of `Top`, captures one record per genuinely retired instruction (PC, instruction word, destination register, written value, decoded format), buffers records in a FIFO, and presents them on a valid/ready stream to the checker or golden-model bridge. It gives consumers a clean one-record-per-retirement stream, with sequence numbers, drop accounting and optional pipeline back-pressure.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `FILTER_NOP`, 1: when 1, an all-zero instruction word is never recorded.
- `STALL_SLACK`, 2: `stall_req` asserts when occupancy ≥ `DEPTH-STALL_SLACK`; 0 disables back-pressure.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wb_retire`  in  1  WB register loaded with a new, non-squashed instruction this cycle (one pulse per retirement).
- `wb_pc`  in  32  PC of the WB instruction.
- `wb_instr`  in  32  instruction word in WB.
- `wb_reg_write`  in  1  WB writes the register file.
- `wb_dest`  in  5  destination register index.
- `wb_data`  in  32  value written back.
- `tr_valid`  out  1  record available.
- `tr_ready`  in  1  consumer accepts.
- `tr_seq`  out  16  retirement sequence number.
- `tr_pc`, `tr_instr`, `tr_wdata`  out  32 each  captured fields.
- `tr_wen`  out  1  captured `wb_reg_write`.
- `tr_rd`  out  5  captured `wb_dest`; forced to 0 when `tr_wen`=0.
- `tr_type`  out  2  0=R, 1=I, 2=J, 3 unused.
- `stall_req`  out  1  request to freeze the pipeline front end.
- `overflow`  out  1  sticky: at least one record dropped.
- `drop_cnt`  out  16  dropped-record count, saturating.
- `clr_overflow`  in  1  synchronous clear of `overflow` and `drop_cnt`.

## Operation
- Capture condition: `wb_retire` && !(`FILTER_NOP` && `wb_instr`==0).
- Format decode at capture from `wb_instr[31:26]`:
  - 0x00 → R.
  - 0x02 or 0x03 → J.
  - All other opcodes → I.
- Every capture consumes the current `seq_ctr` value, then increments it (16-bit, wraps 0xFFFF→0x0000). This includes captures that are dropped, so consumers detect gaps from `tr_seq`.
- Push on capture when FIFO not full, or when full and a pop occurs in the same cycle. Otherwise drop:
  - `overflow`←1.
  - `drop_cnt`+1, saturating at 0xFFFF.
- Pop on `tr_valid && tr_ready`. `tr_*` always show the head entry. `tr_*` must hold stable while `tr_valid && !tr_ready`.
- No bypass: a capture into an empty FIFO is visible the next cycle.
- `clr_overflow` in the same cycle as a drop: the drop wins, so `overflow`=1 and `drop_cnt`=1.
- `stall_req` = (`STALL_SLACK`≠0) && occupancy ≥ `DEPTH-STALL_SLACK`. It is registered from next-state occupancy.

## Timing
- Reset values: `tr_valid`=0; all `tr_*` data=0; `stall_req`=0; `overflow`=0; `drop_cnt`=0; `seq_ctr`=0; FIFO empty.
- Reset asserted mid-stream: the FIFO is discarded immediately (asynchronous). The first capture after release carries `tr_seq`=0.
- Latency: capture at edge N → `tr_valid`=1 after edge N+1, with that record at the head if the FIFO was empty.
- Throughput: one push and one pop per cycle, sustained.
- Full + push + pop in the same cycle: occupancy unchanged, no drop.
- Empty + `tr_ready` high: no pop, no underflow.
- `stall_req` reflects occupancy after the current edge's push and pop. The slack covers the in-flight instructions still arriving at WB.

## Structure
- Package `retire_trace_pkg`:
  - `trace_rec_t` packed struct: seq, pc, instr, wen, rd, wdata, type (120 bits).
  - `instr_fmt_e` enum: R/I/J.
  - Opcode constants `OP_RTYPE`, `OP_J`, `OP_JAL`.
- Sub-module `sync_fifo`:
  - Parameterised by width and depth.
  - Pointers one bit wider than the address, for full/empty detection.
  - Exports occupancy.
- Top level holds the capture/decode logic, sequence counter, drop accounting and stall logic.

## Test plan
- Single retirement: `wb_pc`=0x400, `wb_instr`=0x012A4020 (add), dest 8, data 5, `tr_ready`=1 → one record, `tr_seq`=0, `tr_type`=R, `tr_rd`=8, `tr_wdata`=5, visible one cycle after capture.
- Format decode:
  - 0x08000010 → J.
  - 0x8C080004 (lw) → I.
  - `wb_instr`=0 with `FILTER_NOP`=1 → no record, `seq_ctr` unchanged.
- Back-pressure, `DEPTH`=8: hold `tr_ready`=0 for 10 captures.
  - `stall_req` high once occupancy reaches 6.
  - 2 drops, `overflow`=1, `drop_cnt`=2.
  - Drain yields seqs 0–7.
  - The next capture carries seq 10.
- Full FIFO with simultaneous capture and pop → occupancy stays 8, no drop. `tr_*` stable across 3 stalled cycles.
- Sequence wrap: preload 65535 captures → records with seq 0xFFFF then 0x0000.
- `reset_n` low with 4 entries queued → `tr_valid`=0 immediately. After release, the first record has seq 0. `clr_overflow` clears `drop_cnt` to 0.
